// File: rtl/load_store_unit_if.sv
// Word-bus interface between the load/store unit (master) and memory (slave).
// One request is outstanding at a time; bus_ack completes it.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: one req/ack word-bus transaction per load/store, load alignment and extension.
// Optional MISALIGN_TRAP_EN: retire misaligned H/W accesses with misalign=1 instead of aligning them.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid_i,
  output logic                    ex_ready_o,
  input  logic                    mem_read_i,
  input  logic                    mem_write_i,
  input  logic [2:0]              funct3_i,
  input  logic [31:0]             alu_result_i,
  input  logic [31:0]             store_data_i,
  input  logic [4:0]              rd_in_i,
  input  logic                    flush_i,
  load_store_unit_if.master       bus,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [31:0]             wb_data_o,
  output logic                    done_o,
  output logic                    bus_err_o,
  output logic                    misalign_o
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: align_addr = a;
      3'b001, 3'b101: align_addr = {a[31:1], 1'b0};
      default:        align_addr = {a[31:2], 2'b00};
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = a[0];
      default:        is_misaligned = |a[1:0];
    endcase
  endfunction
`endif

  function automatic logic [3:0] lane_be(input logic [1:0] a, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: lane_be = 4'b0001 << a;
      3'b001, 3'b101: lane_be = 4'b0011 << {a[1], 1'b0};
      default:        lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: lane_wdata = {4{d[7:0]}};
      3'b001, 3'b101: lane_wdata = {2{d[15:0]}};
      default:        lane_wdata = d;
    endcase
  endfunction

  // Byte/half lanes are shifted down to bit 0, then sign- or zero-extended.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] a,
                                               input logic [2:0] f3);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = rdata >> {a, 3'b000};
    half_sh = rdata >> {a[1], 4'b0000};
    case (f3)
      3'b000:  load_extract = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_extract = {24'h000000, byte_sh[7:0]};
      3'b001:  load_extract = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_extract = {16'h0000, half_sh[15:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  logic [1:0]    state_q, state_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    rd_q, rd_d;
  logic          flush_q, flush_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          done_q, done_d;
  logic          bus_err_q, bus_err_d;
  logic          misalign_q, misalign_d;

  logic          accept_s;
  logic          timeout_s;
  logic [31:0]   ea_s;

  assign ex_ready_o = (state_q == ST_IDLE);
  assign accept_s   = ex_valid_i & ex_ready_o & (mem_read_i | mem_write_i) & ~flush_i;
  assign timeout_s  = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1));
  assign ea_s       = align_addr(alu_result_i, funct3_i);

  // Next-state and next-output computation for the IDLE -> REQ -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    flush_d     = flush_q;
    wait_d      = wait_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_lo_d = ea_s[1:0];
          f3_d      = funct3_i;
          rd_d      = rd_in_i;
          flush_d   = 1'b0;
          wait_d    = '0;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(alu_result_i, funct3_i)) begin
            state_d    = ST_RESP;
            done_d     = 1'b1;
            misalign_d = 1'b1;
            wb_rd_d    = rd_in_i;
            wb_data_d  = 32'h0000_0000;
          end else begin
`else
          begin
`endif
            state_d     = ST_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write_i;
            bus_addr_d  = {ea_s[31:2], 2'b00};
            bus_wdata_d = mem_write_i ? lane_wdata(store_data_i, funct3_i) : 32'h0000_0000;
            bus_be_d    = mem_write_i ? lane_be(ea_s[1:0], funct3_i) : 4'b1111;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        flush_d = flush_q | flush_i;
        // A same-cycle ack beats the timeout.
        if (bus.bus_ack) begin
          state_d    = ST_RESP;
          bus_req_d  = 1'b0;
          wait_d     = '0;
          done_d     = 1'b1;
          wb_rd_d    = rd_q;
          wb_valid_d = ~bus_we_q & ~(flush_q | flush_i);
          wb_data_d  = bus_we_q ? 32'h0000_0000 : load_extract(bus.bus_rdata, addr_lo_q, f3_q);
        end else if (timeout_s) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          wait_d    = '0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = 32'h0000_0000;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; async reset abandons any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      f3_q        <= 3'b000;
      rd_q        <= 5'd0;
      flush_q     <= 1'b0;
      wait_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0000_0000;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      flush_q     <= flush_d;
      wait_q      <= wait_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = wb_data_q;
  assign done_o        = done_q;
  assign bus_err_o     = bus_err_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit (TIMEOUT=4) against a spec-level model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, mem_read, mem_write, flush;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_in;
  logic        wb_valid, done, bus_err, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid),
    .ex_ready_o   (ex_ready),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .alu_result_i (alu_result),
    .store_data_i (store_data),
    .rd_in_i      (rd_in),
    .flush_i      (flush),
    .bus          (bus_if),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .done_o       (done),
    .bus_err_o    (bus_err),
    .misalign_o   (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes and the rules for each lane ----
  function automatic int op_size(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (op_size(f3) == 2 && a[0]) || (op_size(f3) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_ea(input logic [2:0] f3, input logic [31:0] a);
    if (op_size(f3) == 2) return a & ~32'd1;
    if (op_size(f3) == 4) return a & ~32'd3;
    return a;
  endfunction

  function automatic logic [3:0] model_be(input bit st, input logic [2:0] f3, input logic [31:0] ea);
    if (!st || op_size(f3) == 4) return 4'b1111;
    if (op_size(f3) == 2) return (ea[1] ? 4'b1100 : 4'b0011);
    return 4'(1 << ea[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (op_size(f3) == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (op_size(f3) == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ea,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * ea[1:0]);
    if (op_size(f3) == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op_size(f3) == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One memory op: ack_k = REQ cycle index that acks (>= TMO: never), flush_k = REQ cycle with flush.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input int ack_k, input logic [31:0] rdata,
                        input int flush_k);
    logic [31:0] ea;
    bit acked, err, flushed;
    ea = model_ea(f3, a);
    @(negedge clk);
    chk1("ready_before", ex_ready, 1'b1);
    ex_valid = 1'b1; mem_write = st; mem_read = !st; funct3 = f3;
    alu_result = a; store_data = d; rd_in = rd;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = $urandom; store_data = $urandom; rd_in = 5'($urandom);
    if (model_misaligned(f3, a)) begin
      chk1("trap_no_req", bus_if.bus_req, 1'b0);
      chk1("trap_done", done, 1'b1);
      chk1("trap_misalign", misalign, 1'b1);
      chk1("trap_wb_valid", wb_valid, 1'b0);
      @(negedge clk);
      chk1("trap_ready_after", ex_ready, 1'b1);
      chk1("trap_done_pulse", done, 1'b0);
      return;
    end
    acked = 1'b0; err = 1'b0; flushed = 1'b0;
    for (int k = 0; k < TMO && !acked; k++) begin
      chk1("req_high", bus_if.bus_req, 1'b1);
      chk1("busy_not_ready", ex_ready, 1'b0);
      chk32("bus_addr", bus_if.bus_addr, {ea[31:2], 2'b00});
      chk1("bus_we", bus_if.bus_we, st);
      chk32("bus_be", 32'(bus_if.bus_be), 32'(model_be(st, f3, ea)));
      if (st) chk32("bus_wdata", bus_if.bus_wdata, model_wdata(f3, d));
      chk1("no_early_done", done, 1'b0);
      if (k == flush_k) begin flush = 1'b1; flushed = 1'b1; end
      if (k == ack_k) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata; acked = 1'b1;
      end else begin
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
      end
      @(negedge clk);
      flush = 1'b0; bus_if.bus_ack = 1'b0;
      if (!acked && k == TMO - 1) err = 1'b1;
    end
    chk1("resp_req_low", bus_if.bus_req, 1'b0);
    chk1("resp_done", done, 1'b1);
    chk1("resp_bus_err", bus_err, err);
    chk1("resp_misalign", misalign, 1'b0);
    chk1("resp_wb_valid", wb_valid, !st && !err && !flushed);
    if (!st && !err && !flushed) begin
      chk32("wb_data", wb_data, model_load(f3, ea, rdata));
      chk32("wb_rd", 32'(wb_rd), 32'(rd));
    end
    if (err) chk32("err_wb_data", wb_data, 32'h0);
    chk1("resp_not_ready", ex_ready, 1'b0);
    @(negedge clk);
    chk1("ready_after", ex_ready, 1'b1);
    chk1("done_pulse", done, 1'b0);
    chk1("wb_valid_pulse", wb_valid, 1'b0);
  endtask

  logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    funct3 = 3'b000; alu_result = 32'h0; store_data = 32'h0; rd_in = 5'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk1("rst_ready", ex_ready, 1'b1);
    chk1("rst_req", bus_if.bus_req, 1'b0);
    chk1("rst_we", bus_if.bus_we, 1'b0);
    chk32("rst_addr", bus_if.bus_addr, 32'h0);
    chk32("rst_wdata", bus_if.bus_wdata, 32'h0);
    chk32("rst_be", 32'(bus_if.bus_be), 32'h0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk32("rst_wb_data", wb_data, 32'h0);
    chk32("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_misalign", misalign, 1'b0);
    rst_n = 1'b1;

    // Directed cases from the block description.
    run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 2, 32'h0, -1);
    run_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0, 32'h0, -1);
    run_op(1'b0, 3'b000, 32'h0000_0102, 32'h0, 5'd7, 1, 32'h0080_FF00, -1);
    chk32("lb_literal", wb_data, 32'hFFFF_FF80);
    run_op(1'b0, 3'b100, 32'h0000_0102, 32'h0, 5'd9, 0, 32'h0080_FF00, -1);
    chk32("lbu_literal", wb_data, 32'h0000_0080);
    run_op(1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd3, 0, 32'h1234_8765, -1);
    run_op(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd4, 99, 32'h0, -1);
    run_op(1'b0, 3'b010, 32'h0000_0204, 32'h0, 5'd5, TMO - 1, 32'hCAFE_F00D, -1);
    run_op(1'b0, 3'b010, 32'h0000_0208, 32'h0, 5'd6, 2, 32'h1111_2222, 1);
    run_op(1'b1, 3'b001, 32'h0000_030E, 32'h0000_BEEF, 5'd0, 1, 32'h0, 0);

    // Ops that must be ignored: flush at accept, neither read nor write, ack while idle.
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; flush = 1'b1; alu_result = 32'h400;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0; flush = 1'b0;
    chk1("flush_blocks_accept", bus_if.bus_req, 1'b0);
    chk1("flush_blocks_ready", ex_ready, 1'b1);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk1("nop_ignored", bus_if.bus_req, 1'b0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    chk1("idle_ack_no_done", done, 1'b0);
    chk1("idle_ack_no_wb", wb_valid, 1'b0);

    // Async reset while a load waits in REQ.
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h500; rd_in = 5'd1;
    @(negedge clk);
    ex_valid = 1'b0; mem_read = 1'b0;
    chk1("pre_reset_req", bus_if.bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("reset_drops_req", bus_if.bus_req, 1'b0);
    chk1("reset_ready", ex_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    chk1("reset_no_done", done, 1'b0);
    chk1("reset_no_wb", wb_valid, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      bit st;
      int fk;
      st = 1'($urandom_range(0, 1));
      fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_op(st, f3_tab[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, 5)), $urandom, fk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
